ch4_noise_gen: RTL

Channel 4 (noise) generator core, sitting directly downstream of the channel 4 register page. It consumes the decoded NR41–NR44 fields and strobes, and runs four pieces of state: the frequency divider and shift prescaler, the 15/7-bit LFSR, the volume envelope, and the length counter. It produces the 4-bit digital sample and the channel-active flag for the mixer/DAC stage.

---
 rtl/ch4_noise_gen_if.sv | 34 +++
 rtl/ch4_noise_gen.sv | 111 +++++++++++
 2 files changed

// File: rtl/ch4_noise_gen_if.sv
// Channel 4 noise generator port bundle: decoded NR41-NR44 fields/strobes in,
// sample, active flag and LFSR state out.
interface ch4_noise_gen_if #(
   parameter int unsigned DIV_W = 3
);
   logic             ch4_tick;
   logic             tick_256hz;
   logic             tick_64hz;
   logic             ch4_restart;
   logic             length_wr;
   logic [5:0]       length_data;
   logic             length_en;
   logic [3:0]       env_init;
   logic             env_up;
   logic [2:0]       env_period;
   logic [3:0]       shift_s;
   logic             width7;
   logic [DIV_W-1:0] div_r;
   logic             ch4_active;
   logic [3:0]       ch4_out;
   logic [14:0]      lfsr_q;

   modport master (
      output ch4_tick, tick_256hz, tick_64hz, ch4_restart, length_wr, length_data,
             length_en, env_init, env_up, env_period, shift_s, width7, div_r,
      input  ch4_active, ch4_out, lfsr_q
   );

   modport slave (
      input  ch4_tick, tick_256hz, tick_64hz, ch4_restart, length_wr, length_data,
             length_en, env_init, env_up, env_period, shift_s, width7, div_r,
      output ch4_active, ch4_out, lfsr_q
   );
endinterface

// File: rtl/ch4_noise_gen.sv
// Channel 4 noise core: frequency divider + shift prescaler, 15/7-bit LFSR,
// volume envelope and length counter feeding the mixer.
module ch4_noise_gen #(
   parameter int unsigned DIV_W = 3,
   parameter int unsigned PRE_W = 14
) (
   input logic            clk,
   input logic            napu_reset,
   ch4_noise_gen_if.slave bus
);

   logic             active_q, active_d;
   logic [14:0]      sr_q, sr_d;
   logic [3:0]       vol_q, vol_d;
   logic [2:0]       env_cnt_q, env_cnt_d;
   logic [6:0]       len_cnt_q, len_cnt_d;
   logic [6:0]       div_cnt_q, div_cnt_d;
   logic [PRE_W-1:0] pre_q, pre_d;

   logic [DIV_W-1:0] div_r;
   logic [6:0]       div_base;
   logic [PRE_W-1:0] pre_inc, pre_mask;
   logic             dac_on, expiry, shift_en, fb;

   assign div_r = bus.div_r;

   always_comb begin
      div_base = (div_r == '0) ? 7'd2 : (7'(div_r) << 2);
      dac_on   = (bus.env_init != 4'd0) || bus.env_up;
      // a count of 0 (post-reset) also expires on the next tick
      expiry   = bus.ch4_tick && (div_cnt_q <= 7'd1);
      pre_inc  = pre_q + PRE_W'(1);
      pre_mask = ~({PRE_W{1'b1}} << bus.shift_s);
      shift_en = expiry && (32'(bus.shift_s) < PRE_W) && ((pre_inc & pre_mask) == '0);
      fb       = sr_q[0] ^ sr_q[1];
   end

   always_comb begin
      active_d  = active_q;
      sr_d      = sr_q;
      vol_d     = vol_q;
      env_cnt_d = env_cnt_q;
      len_cnt_d = len_cnt_q;
      div_cnt_d = div_cnt_q;
      pre_d     = pre_q;
      if (bus.ch4_restart) begin
         active_d  = dac_on;
         sr_d      = 15'h7FFF;
         vol_d     = bus.env_init;
         env_cnt_d = bus.env_period;
         div_cnt_d = div_base;
         pre_d     = '0;
         if (len_cnt_q == 7'd0) len_cnt_d = 7'd64;
      end else begin
         if (expiry) begin
            div_cnt_d = div_base;
            pre_d     = pre_inc;
         end else if (bus.ch4_tick) begin
            div_cnt_d = div_cnt_q - 7'd1;
         end
         if (shift_en) begin
            sr_d = {fb, sr_q[14:1]};
            if (bus.width7) sr_d[6] = fb;
         end
         if (bus.tick_64hz && (bus.env_period != 3'd0)) begin
            if (env_cnt_q <= 3'd1) begin
               env_cnt_d = bus.env_period;
               if (bus.env_up) begin
                  if (vol_q != 4'd15) vol_d = vol_q + 4'd1;
               end else if (vol_q != 4'd0) begin
                  vol_d = vol_q - 4'd1;
               end
            end else begin
               env_cnt_d = env_cnt_q - 3'd1;
            end
         end
         if (bus.tick_256hz && bus.length_en && (len_cnt_q != 7'd0) && !bus.length_wr) begin
            len_cnt_d = len_cnt_q - 7'd1;
            if (len_cnt_q == 7'd1) active_d = 1'b0;
         end
      end
      // a write, even alongside a trigger, loads the fresh length
      if (bus.length_wr) len_cnt_d = 7'd64 - {1'b0, bus.length_data};
      if (!dac_on) active_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!napu_reset) begin
         active_q  <= 1'b0;
         sr_q      <= 15'h7FFF;
         vol_q     <= 4'd0;
         env_cnt_q <= 3'd0;
         len_cnt_q <= 7'd0;
         div_cnt_q <= 7'd0;
         pre_q     <= '0;
      end else begin
         active_q  <= active_d;
         sr_q      <= sr_d;
         vol_q     <= vol_d;
         env_cnt_q <= env_cnt_d;
         len_cnt_q <= len_cnt_d;
         div_cnt_q <= div_cnt_d;
         pre_q     <= pre_d;
      end
   end

   assign bus.ch4_active = active_q;
   assign bus.ch4_out    = (active_q && !sr_q[0]) ? vol_q : 4'd0;
   assign bus.lfsr_q     = sr_q;

endmodule
